// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage pipelined subtractor (diff = a - b - borrow_in). Stage 1 precomputes
// per-block differences for both incoming borrows; stage 2 ripples the block borrow and selects.
module carry_select_subtractor_pipe #(
    parameter int W   = 64,
    parameter int BLK = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         ovf
);

    localparam int NB = W / BLK;

    // Valid/ready: a transfer happens on a rising edge where valid & ready are both high.
    // A stage advances when its downstream slot is empty or being drained this cycle, so
    // in_ready never depends on in_valid and valid never depends combinationally on ready.
    logic s2_en;
    logic s1_en;

    // Per-block precomputed differences (bit BLK of each sum is the block borrow)
    logic [NB-1:0][BLK:0]   sub0_c;
    logic [NB-1:0][BLK:0]   sub1_c;
    logic [NB-1:0][BLK-1:0] d0_c;
    logic [NB-1:0][BLK-1:0] d1_c;
    logic [NB-1:0]          bo0_c;
    logic [NB-1:0]          bo1_c;

    // Stage 1 registers
    logic                   s1_valid_q;
    logic [NB-1:0][BLK-1:0] s1_d0_q;
    logic [NB-1:0][BLK-1:0] s1_d1_q;
    logic [NB-1:0]          s1_bo0_q;
    logic [NB-1:0]          s1_bo1_q;
    logic                   s1_amsb_q;
    logic                   s1_bmsb_q;
    logic                   s1_bin_q;

    // Stage 2 registers and their next-state values
    logic                   s2_valid_q;
    logic [W-1:0]           diff_q;
    logic [W-1:0]           diff_d;
    logic                   borrow_q;
    logic                   borrow_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   br_c;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        assign sub0_c[k] = {1'b0, a[k*BLK +: BLK]} - {1'b0, b[k*BLK +: BLK]};
        assign sub1_c[k] = sub0_c[k] - {{BLK{1'b0}}, 1'b1};
        assign d0_c[k]   = sub0_c[k][BLK-1:0];
        assign d1_c[k]   = sub1_c[k][BLK-1:0];
        assign bo0_c[k]  = sub0_c[k][BLK];
        assign bo1_c[k]  = sub1_c[k][BLK];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_d0_q    <= '0;
            s1_d1_q    <= '0;
            s1_bo0_q   <= '0;
            s1_bo1_q   <= '0;
            s1_amsb_q  <= 1'b0;
            s1_bmsb_q  <= 1'b0;
            s1_bin_q   <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_d0_q   <= d0_c;
                s1_d1_q   <= d1_c;
                s1_bo0_q  <= bo0_c;
                s1_bo1_q  <= bo1_c;
                s1_amsb_q <= a[W-1];
                s1_bmsb_q <= b[W-1];
                s1_bin_q  <= borrow_in;
            end
        end
    end

    // Block borrow chain: each block's incoming borrow picks its difference and outgoing borrow
    always_comb begin
        br_c   = s1_bin_q;
        diff_d = '0;
        for (int k = 0; k < NB; k++) begin
            diff_d[k*BLK +: BLK] = br_c ? s1_d1_q[k] : s1_d0_q[k];
            br_c                 = br_c ? s1_bo1_q[k] : s1_bo0_q[k];
        end
        borrow_d = br_c;
        ovf_d    = (s1_amsb_q != s1_bmsb_q) && (diff_d[W-1] != s1_amsb_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Directed-vector and scoreboard bench for carry_select_subtractor_pipe (W=64, BLK=8).
module tb_carry_select_subtractor_pipe;

    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    carry_select_subtractor_pipe #(.W(W), .BLK(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
    } vec_t;

    vec_t         vecs[12];
    int           checks = 0;
    int           errors = 0;
    int           pops   = 0;
    bit           mon_en = 1'b0;
    logic [W+1:0] exp_q[$];

    task automatic check(input string name, input logic [W+1:0] got, input logic [W+1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Flat reference: borrow is the sign bit of the (W+1)-bit difference
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        logic [W:0]   t;
        logic         o;
        t = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        o = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
        return {o, t[W], t[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; presents one op and records it if it is accepted this cycle.
    task automatic present(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                           output bit accepted);
        a         = va;
        b         = vb;
        borrow_in = vbin;
        in_valid  = 1'b1;
        #1;
        accepted = in_ready;
        if (accepted) exp_q.push_back(model(va, vb, vbin));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        #3;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard ----------------
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (mon_en && out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {ovf, borrow_out, diff}, 'x);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", {ovf, borrow_out, diff}, e);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bit           acc;
        int           lat;
        int           idx;
        int           p0;
        logic [W+1:0] held;
        bit           have_held;
        logic [W-1:0] ra[8];
        logic [W-1:0] rb[8];
        logic         rbin[8];

        vecs[0]  = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[1]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[2]  = '{64'h0100_0000_0000_0000, 64'h0, 1'b1, 64'h00FF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[3]  = '{64'h5, 64'h3, 1'b0, 64'h2, 1'b0, 1'b0};
        vecs[4]  = '{64'h5, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     64'h8000_0000_0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[8]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                     64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0};
        vecs[9]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 1'b0, 1'b1};
        vecs[10] = '{64'h100, 64'h1, 1'b0, 64'hFF, 1'b0, 1'b0};
        vecs[11] = '{64'h1, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {ovf, borrow_out, diff}, 0);
        check("reset_in_ready", in_ready, 1);

        // Directed table: one op at a time, latency and value checked
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            a         = vecs[i].a;
            b         = vecs[i].b;
            borrow_in = vecs[i].bin;
            in_valid  = 1'b1;
            #1;
            check("vec_in_ready", in_ready, 1);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (lat < 10) begin
                @(negedge clock);
                if (out_valid) break;
                @(posedge clock);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_result", i), {ovf, borrow_out, diff},
                  {vecs[i].ovf, vecs[i].bo, vecs[i].diff});
        end
        @(negedge clock);

        // Reset mid-stream with two ops in flight
        out_ready = 1'b0;
        present(64'h55, 64'h11, 1'b0, acc);
        @(negedge clock);
        present(64'h99, 64'h22, 1'b1, acc);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("reset_async_valid", out_valid, 0);
        check("reset_async_diff", diff, 0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            check("no_stale_result", out_valid, 0);
        end
        check("post_reset_in_ready", in_ready, 1);

        // Back-to-back random stream
        mon_en = 1'b1;
        p0     = pops;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            present({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
            check("stream_in_ready", acc, 1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        drain(20);
        check("stream_count", pops - p0, 100);

        // Output stall with input pressure, then release
        for (int i = 0; i < 8; i++) begin
            ra[i]   = {$urandom, $urandom};
            rb[i]   = {$urandom, $urandom};
            rbin[i] = 1'($urandom_range(0, 1));
        end
        p0        = pops;
        idx       = 0;
        have_held = 1'b0;
        held      = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            present(ra[idx], rb[idx], rbin[idx], acc);
            if (acc) idx++;
            if (out_valid) begin
                if (have_held) check("stall_hold", {ovf, borrow_out, diff}, held);
                held      = {ovf, borrow_out, diff};
                have_held = 1'b1;
            end
        end
        check("stall_accepts", idx, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_held_value", held, model(ra[0], rb[0], rbin[0]));
        @(negedge clock);
        out_ready = 1'b1;
        present(ra[idx], rb[idx], rbin[idx], acc);
        check("pop_push_in_ready", acc, 1);
        if (acc) idx++;
        while (idx < 8) begin
            @(negedge clock);
            present(ra[idx], rb[idx], rbin[idx], acc);
            if (acc) idx++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        drain(20);
        check("stall_count", pops - p0, 8);
        repeat (3) @(negedge clock);
        #1;
        check("no_duplicate", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
